// File: rtl/noc_credit_router.sv
// noc_credit_router: RADIX_IN x RADIX_OUT crossbar stage with credit flow control; define NOC_OUT_REG_EN to register enq_out/flit_out
module noc_credit_router #(
  parameter int RADIX_IN   = 4,
  parameter int RADIX_OUT  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CREDITS    = 2,
  parameter int LAYER      = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_l,
  input  logic [RADIX_IN-1:0]                          enq_in,
  input  logic [RADIX_IN*(ADDR_WIDTH+DATA_WIDTH)-1:0]  flit_in,
  output logic [RADIX_IN-1:0]                          credit_out,
  output logic [RADIX_OUT-1:0]                         enq_out,
  output logic [RADIX_OUT*(ADDR_WIDTH+DATA_WIDTH)-1:0] flit_out,
  input  logic [RADIX_OUT-1:0]                         credit_in
);
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam int L  = $clog2(RADIX_OUT);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int QW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = $clog2(RADIX_IN);

  if (ADDR_WIDTH < L * (LAYER + 1)) begin : g_bad_layer
    $error("noc_credit_router: ADDR_WIDTH too small for the selected LAYER");
  end

  logic [RADIX_IN-1:0]     valid;
  logic [RADIX_IN-1:0]     deq;
  logic [FW-1:0]           head [RADIX_IN];
  logic [L-1:0]            dest [RADIX_IN];
  logic [RADIX_IN-1:0]     gnt  [RADIX_OUT];
  logic [RADIX_OUT-1:0]    enq_x;
  logic [RADIX_OUT*FW-1:0] flit_x;

  for (genvar i = 0; i < RADIX_IN; i++) begin : g_in
    logic [FW-1:0] mem [DEPTH];
    logic [PW-1:0] rd;
    logic [PW-1:0] wr;
    logic [QW-1:0] cnt;
    logic          push;
    assign push     = enq_in[i] && (cnt != QW'(DEPTH) || deq[i]);
    assign valid[i] = cnt != '0;
    assign head[i]  = valid[i] ? mem[rd] : '0;
    assign dest[i]  = head[i][FW-1-L*LAYER -: L];
    // storage needs no reset: an empty FIFO masks its head to zero
    always_ff @(posedge clk)
      if (push) mem[wr] <= flit_in[i*FW +: FW];
    // pointers and occupancy; a full FIFO still takes a write in the cycle it pops
    always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
        rd  <= '0;
        wr  <= '0;
        cnt <= '0;
      end else begin
        if (enq_in[i] && !push) $error("noc_credit_router: enq on full input FIFO %0d, flit dropped", i);
        if (push) wr <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
        if (deq[i]) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
        cnt <= cnt + QW'(push) - QW'(deq[i]);
      end
  end

  for (genvar j = 0; j < RADIX_OUT; j++) begin : g_out
    logic [RADIX_IN-1:0] req;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       crd;
    logic                any;
    logic [FW-1:0]       fm;
    // an input requests this output only while a downstream credit is held
    always_comb begin
      req = '0;
      for (int i = 0; i < RADIX_IN; i++) req[i] = valid[i] && dest[i] == L'(j) && crd != '0;
    end
    // scan from the farthest slot back so the nearest requester at or after ptr wins
    always_comb begin
      any  = 1'b0;
      gidx = '0;
      idx  = '0;
      for (int k = RADIX_IN - 1; k >= 0; k--) begin
        idx = IW'((int'(ptr) + k) % RADIX_IN);
        if (req[idx]) begin
          any  = 1'b1;
          gidx = idx;
        end
      end
    end
    assign gnt[j] = any ? {{(RADIX_IN-1){1'b0}}, 1'b1} << gidx : '0;
    // crossbar column: select the granted head
    always_comb begin
      fm = '0;
      for (int i = 0; i < RADIX_IN; i++) fm = fm | (gnt[j][i] ? head[i] : '0);
    end
    assign enq_x[j]           = any;
    assign flit_x[j*FW +: FW] = fm;
    // credit counter and round-robin pointer; an extra credit at full count saturates
    always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
        crd <= CW'(CREDITS);
        ptr <= '0;
      end else begin
        if (any) ptr <= gidx == IW'(RADIX_IN - 1) ? '0 : gidx + 1'b1;
        if (credit_in[j] && !any && crd == CW'(CREDITS)) $error("noc_credit_router: credit overflow on output %0d", j);
        else crd <= crd - CW'(any) + CW'(credit_in[j]);
      end
  end

  // an input dequeues when any output column grants it
  always_comb begin
    deq = '0;
    for (int j = 0; j < RADIX_OUT; j++) deq = deq | gnt[j];
  end

  // each dequeue returns one FIFO slot upstream on the following cycle
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) credit_out <= '0;
    else credit_out <= deq;

`ifdef NOC_OUT_REG_EN
  // output register after the crossbar; arbitration timing is unchanged
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      enq_out  <= '0;
      flit_out <= '0;
    end else begin
      enq_out  <= enq_x;
      flit_out <= flit_x;
    end
`else
  assign enq_out  = enq_x;
  assign flit_out = flit_x;
`endif
endmodule

// File: doc/noc_credit_router.md
# noc_credit_router

Parametrised RADIX_IN × RADIX_OUT crossbar router stage for the multi-layer memory NoC, replacing full/almost-full backpressure with credit-based flow control on both sides. Each input owns a FIFO whose head flit is routed by a layer-selected address field to one output. Each output arbitrates round-robin among requesting inputs and forwards a flit only while it holds a downstream credit. Stages cascade through LAYER: one stage's credit_out drives the upstream stage's credit_in.

## Interface
- RADIX_IN, 4, number of input ports (≥2)
- RADIX_OUT, 8, number of output ports (power of 2, ≥2)
- ADDR_WIDTH, 16, address field width; flit = {addr, data}
- DATA_WIDTH, 32, payload width
- DEPTH, 2, input FIFO depth per input (≥1)
- CREDITS, 2, downstream buffer depth per output = initial credit count (≥1)
- LAYER, 0, network layer index selecting the address field

- clk  in  1  clock; all state on posedge
- rst_l  in  1  reset; one clock, asynchronous, active-low
- enq_in  in  RADIX_IN  flit valid per input
- flit_in  in  RADIX_IN×(ADDR_WIDTH+DATA_WIDTH)  input flits, address in MSBs
- credit_out  out  RADIX_IN  one-cycle pulse returning one input-FIFO slot upstream
- enq_out  out  RADIX_OUT  flit valid per output
- flit_out  out  RADIX_OUT×(ADDR_WIDTH+DATA_WIDTH)  output flits
- credit_in  in  RADIX_OUT  one-cycle pulse: downstream freed one slot

## Operation
- Input FIFO: circular buffer, combinational head; head reads 0 when empty. enq_in with FIFO full: protocol error, $error, flit dropped; a read and write in the same cycle on a full FIFO are both allowed.
- Decode: L = $clog2(RADIX_OUT); dest = addr[ADDR_WIDTH-1-L*LAYER -: L]. Elaboration error if ADDR_WIDTH < L*(LAYER+1).
- Request req[j][i] = FIFO i non-empty && dest_i == j && credit[j] != 0.
- Arbiter per output: rotating priority from ptr[j]; grant lowest index ≥ ptr[j], wrapping. Grant issued: ptr[j] ← (granted index + 1) mod RADIX_IN. No grant: ptr[j] holds.
- Each input requests one output, so there is at most one grant per input. A granted input dequeues at the edge.
- Credit counter per output, width $clog2(CREDITS+1): next = cnt − grant_j + credit_in[j]. Grant and credit_in in the same cycle leave it unchanged.
- credit_in while cnt == CREDITS and no grant: $error; counter saturates at CREDITS.
- credit_out[i] is a registered copy of the input-i dequeue.
- The upstream stage initialises its credit counters for this stage to DEPTH.
- Mid-operation reset: all FIFO contents, credits and pointers are discarded immediately, with no partial output.

## Timing
- Reset values: enq_out = 0, flit_out = 0, credit_out = 0, every credit[j] = CREDITS, every ptr[j] = 0, all FIFOs empty.
- Without NOC_OUT_REG_EN:
  - A flit enqueued at edge t appears on flit_out with enq_out during cycle t+1, provided it is at the head, granted and credit is available.
  - The FIFO pops at the end of cycle t+1.
  - credit_out pulses in cycle t+2.
- Sustained throughput is 1 flit/cycle/output while credits last. With CREDITS ≥ round-trip, throughput is 1 flit/cycle.
- credit_in at edge t raises the counter at that edge; a grant that uses it can occur in cycle t+1.
- A zero-credit output stalls without dropping data. Requesting inputs hold their head; other inputs bound for other outputs are unaffected (head-of-line blocking is accepted).

## Configuration
- NOC_OUT_REG_EN defined:
  - enq_out/flit_out are registered after the crossbar, reset to 0.
  - Enqueue-to-output latency is 2 cycles.
  - Grant, dequeue and credit decrement still occur in the arbitration cycle.
  - Throughput is unchanged.
- NOC_OUT_REG_EN undefined: outputs are combinational from FIFO head through the mux, latency 1 cycle.

## Test plan
- Reset, then idle for 5 cycles → enq_out=0, credit_out=0, flit_out=0; no credit_in pulses, so internal credits stay at 2 with no errors.
- Single flit: input 0 sends addr=0x2000, data=0xA5A5A5A5 (LAYER=0, dest 1) → enq_out[1] in cycle t+1 with the same flit, credit_out[0] in cycle t+2. With NOC_OUT_REG_EN the flit appears in t+2.
- Contention: inputs 0–3 each hold 2 flits to dest 3, with credit_in[3] returned every cycle → grant order 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
- Credit exhaustion: CREDITS=2, no credit_in, 4 flits queued to output 5 → exactly 2 enq_out[5] pulses, then stall. A single credit_in[5] pulse releases exactly one more flit on the next cycle.
- Simultaneous grant and credit_in on output 2 at credit=1 → counter stays 1; transfers continue back-to-back.
- LAYER=1, addr=0x0E00 → dest = addr[12:10] = 3; enq_out[3] only. Reset asserted mid-burst → outputs 0 and credits back to CREDITS in the same cycle.
